// File: rtl/prbs_loop_checker.sv
// prbs_loop_checker: PRBS loopback receiver that seeds from, locks onto and error-counts a PN stream
module prbs_loop_checker #(
  parameter logic [31:0] POL_MASK = 32'h0000_00C0,
  parameter int POL_W = 7,
  parameter int DW = 16,
  parameter int LOCK_CNT = 4,
  parameter int UNLOCK_ERR = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DW-1:0]    data_in,
  input  logic             data_valid,
  input  logic             clear_cnt,
  output logic             locked,
  output logic             err_word,
  output logic [CNT_W-1:0] err_bit_cnt,
  output logic [CNT_W-1:0] word_cnt
);
  localparam int NW = $clog2(DW + 1);
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(UNLOCK_ERR + 1);
  typedef enum logic {SEARCH, LOCKED} state_t;
  state_t state, state_n;
  logic [POL_W-1:0] seed, seed_n;
  logic [GW-1:0] good_cnt, good_n;
  logic [BW-1:0] bad_cnt, bad_n;
  logic prev_ok, prev_ok_n, err_n, match;
  logic [CNT_W-1:0] ebc_n, wc_n;
  logic [CNT_W:0] ebc_sum;
  logic [DW-1:0] expected, diff;
  logic [NW-1:0] nerr;
  // Bits are produced oldest-first, so each one only looks at older bits above it
  function automatic logic [DW-1:0] pn(input logic [POL_W-1:0] s);
    logic [POL_W+DW-1:0] ext;
    ext = {s, {DW{1'b0}}};
    for (int i = DW - 1; i >= 0; i--) ext[i] = ^(ext[i +: POL_W+1] & POL_MASK[POL_W:0]);
    return ext[DW-1:0];
  endfunction
  assign expected = pn(seed);
  assign diff = data_in ^ expected;
  assign nerr = NW'($countones(diff));
  assign match = prev_ok && seed != '0 && diff == '0;
  assign ebc_sum = {1'b0, err_bit_cnt} + (CNT_W+1)'(nerr);
  assign locked = state == LOCKED;
  always_comb begin
    state_n = state;
    seed_n = seed;
    good_n = good_cnt;
    bad_n = bad_cnt;
    prev_ok_n = prev_ok;
    err_n = 1'b0;
    ebc_n = err_bit_cnt;
    wc_n = word_cnt;
    if (data_valid && state == SEARCH) begin
      prev_ok_n = 1'b1;
      good_n = match ? good_cnt + GW'(1) : '0;
      seed_n = data_in[POL_W-1:0];
      if (good_n == GW'(LOCK_CNT)) begin
        state_n = LOCKED;
        seed_n = expected[POL_W-1:0];
        bad_n = '0;
      end
    end else if (data_valid) begin
      seed_n = expected[POL_W-1:0];
      err_n = nerr != '0;
      bad_n = err_n ? bad_cnt + BW'(1) : '0;
      ebc_n = ebc_sum[CNT_W] ? '1 : ebc_sum[CNT_W-1:0];
      wc_n = &word_cnt ? word_cnt : word_cnt + CNT_W'(1);
      if (bad_n == BW'(UNLOCK_ERR)) begin
        state_n = SEARCH;
        good_n = '0;
        prev_ok_n = 1'b0;
      end
    end
    if (clear_cnt) begin
      ebc_n = '0;
      wc_n = '0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SEARCH;
      seed <= '0;
      good_cnt <= '0;
      bad_cnt <= '0;
      prev_ok <= 1'b0;
      err_word <= 1'b0;
      err_bit_cnt <= '0;
      word_cnt <= '0;
    end else begin
      state <= state_n;
      seed <= seed_n;
      good_cnt <= good_n;
      bad_cnt <= bad_n;
      prev_ok <= prev_ok_n;
      err_word <= err_n;
      err_bit_cnt <= ebc_n;
      word_cnt <= wc_n;
    end
  end
endmodule

// File: doc/prbs_loop_checker.md
# prbs_loop_checker

Sequential checker/controller wrapped around the parallel PN generator (same POL_MASK/POL_W/DW convention, same bit ordering). It sits at the receive end of a PRBS loopback path. It seeds the PN generator from received words, declares lock after a run of correctly predicted words, then free-runs the generator, counting bit errors and dropping lock on sustained errors. Status and counters go to the debug/CSR layer.

## Interface
- POL_MASK, 32'h0000_00C0, tap mask applied to each POL_W+1-bit window (PRBS7, x^7+x^6+1).
- POL_W, 7, PN state width; DW must be >= POL_W.
- DW, 16, data word width.
- LOCK_CNT, 4, consecutive matching words needed to lock (>= 1).
- UNLOCK_ERR, 4, consecutive errored words that drop lock (>= 1).
- CNT_W, 32, width of err_bit_cnt and word_cnt.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- data_in  in  DW  received word; bit DW-1 oldest, bit 0 newest.
- data_valid  in  1  data_in valid this cycle; no backpressure.
- clear_cnt  in  1  synchronous clear of err_bit_cnt and word_cnt.
- locked  out  1  checker in LOCKED state.
- err_word  out  1  one-cycle pulse: the last checked locked word had at least 1 bit error.
- err_bit_cnt  out  CNT_W  saturating count of bit errors while locked.
- word_cnt  out  CNT_W  saturating count of words checked while locked.

## Operation
- Prediction: expected = PN(seed), where pn[i] = ^({seed, pn}[i +: POL_W+1] & POL_MASK). This is the same function as the PN generator, instantiated or inlined.
- Next seed is always the newest POL_W bits of a word, i.e. word[POL_W-1:0].
- FSM states: SEARCH (reset state), LOCKED.
- SEARCH:
  - The seed is taken from received data.
  - prev_ok flag: cleared by reset and on entry to SEARCH; set on any valid word.
  - On a valid word with prev_ok=1 and seed != 0, compare data_in against PN(seed).
    - Match: good_cnt++.
    - Mismatch: good_cnt=0.
  - A seed of 0 never counts as a match; good_cnt is set to 0.
  - The seed register loads data_in[POL_W-1:0].
  - When good_cnt reaches LOCK_CNT: go to LOCKED, seed loads expected[POL_W-1:0] (equal to data_in on a match), bad_cnt=0.
- LOCKED:
  - The seed free-runs from the prediction only: seed <= expected[POL_W-1:0]. Received data never reseeds.
  - Per valid word: nerr = popcount(data_in ^ expected), width clog2(DW+1).
  - err_bit_cnt += nerr, saturating at all ones.
  - word_cnt += 1, saturating.
  - nerr != 0: err_word pulses and bad_cnt++.
  - nerr == 0: bad_cnt=0.
  - When bad_cnt reaches UNLOCK_ERR: go to SEARCH, clear good_cnt and prev_ok. That word's errors are still counted.
- data_valid=0: no state, counter or seed change; err_word=0.
- clear_cnt: in the cycle it is asserted, err_bit_cnt and word_cnt become 0. Clear has priority: a word checked in the same cycle contributes nothing. The FSM, good_cnt and bad_cnt are unaffected.
- The counters hold their values across lock loss; only reset or clear_cnt zeroes them.

## Timing
- All outputs are registered. Reset values: locked=0, err_word=0, err_bit_cnt=0, word_cnt=0. Internally: state=SEARCH, seed=0, good_cnt=0, bad_cnt=0, prev_ok=0.
- Asserting rst mid-operation forces all of the above immediately (asynchronously); lock and counters are lost.
- Latency: a word presented in cycle N with data_valid=1 updates its results in cycle N+1:
  - err_word,
  - counters,
  - locked rise (LOCK_CNT-th match),
  - locked fall (UNLOCK_ERR-th consecutive errored word).
- Back-to-back valid words are supported every cycle, at full rate.
- Minimum lock time from reset with clean data: LOCK_CNT+1 valid words, because the first word only seeds.

## Test plan
- Seed word with low bits 7'h7F, then clean PRBS7 (first predicted word 16'h020C, next seed 7'h0C), LOCK_CNT=4 -> locked rises one cycle after the 5th valid word; err_bit_cnt=0; word_cnt counts subsequent words only.
- Once locked, flip 3 bits in one word -> err_word pulses once, err_bit_cnt=3, locked stays 1, bad_cnt returns to 0 on the next clean word.
- Once locked, corrupt 4 consecutive words (1 bit each) -> locked falls the cycle after the 4th, err_bit_cnt=4; clean data afterwards relocks after 5 more valid words.
- Continuous all-zero input -> locked never asserts; valid gaps mid-search do not reset good_cnt.
- Force err_bit_cnt near saturation (CNT_W=4, all-ones data vs prediction) -> count sticks at 4'hF. Assert clear_cnt together with an errored word -> both counters read 0 next cycle.
- Assert rst asynchronously while locked mid-stream -> all outputs 0 immediately, without a clock edge; relock requires the full seed + LOCK_CNT sequence.
